// File: rtl/cachepool_refill_arbiter.sv
// Round-robin sharing of one AXI read port among NumReq cache-line refill requesters; R beats steered back by ID.
// Request-to-AR latency is 1 cycle; the AR register stalls on ar_ready_i, and the R path passes the owner's rsp_ready_i straight through.
module cachepool_refill_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 256,
    parameter int unsigned LineWidth      = 512,
    parameter int unsigned IdWidth        = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    output logic [NumReq-1:0]           rsp_valid_o,
    input  logic [NumReq-1:0]           rsp_ready_i,
    output logic [DataWidth-1:0]        rsp_data_o,
    output logic                        rsp_last_o,
    output logic                        rsp_err_o,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [AddrWidth-1:0]        ar_addr_o,
    output logic [IdWidth-1:0]          ar_id_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [DataWidth-1:0]        r_data_i,
    input  logic [IdWidth-1:0]          r_id_i,
    input  logic                        r_last_i,
    input  logic [1:0]                  r_resp_i,
    output logic                        id_err_o
);

    localparam int unsigned Beats = LineWidth / DataWidth;
    localparam int unsigned OffW  = $clog2(LineWidth / 8);
    localparam int unsigned PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam logic [AddrWidth-1:0] LineMask = ~((AddrWidth'(1) << OffW) - AddrWidth'(1));

    logic                 r_ar_valid;
    logic [AddrWidth-1:0] r_ar_addr;
    logic [IdWidth-1:0]   r_ar_id;
    logic [PtrW-1:0]      r_ptr;
    logic [CntW-1:0]      r_cnt [NumReq];
    logic                 r_id_err;

    logic [NumReq-1:0]    w_elig;
    logic [NumReq-1:0]    w_id_hit;
    logic [NumReq-1:0]    w_req_hs;
    logic [PtrW-1:0]      w_cand;
    logic [PtrW-1:0]      w_win;
    logic [AddrWidth-1:0] w_sel_addr;
    logic                 w_found;
    logic                 w_ar_free;
    logic                 w_grant;
    logic                 w_id_ok;
    logic                 w_r_last_hs;

    always_comb begin
        for (int i = 0; i < int'(NumReq); i++) begin
            w_elig[i]   = req_valid_i[i] && (r_cnt[i] < CntW'(MaxOutstanding));
            w_id_hit[i] = (r_id_i == IdWidth'(i));
        end
    end

    // First eligible requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            w_cand = PtrW'((int'(r_ptr) + k) % int'(NumReq));
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_ar_free  = !r_ar_valid || ar_ready_i;
    assign w_grant    = w_ar_free && w_found;
    assign w_sel_addr = req_addr_i[int'(w_win)*AddrWidth +: AddrWidth];

    always_comb begin
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_win] = 1'b1;
        end
    end

    assign w_req_hs = req_ready_o & req_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_id    <= '0;
            r_ptr      <= '0;
        end else if (w_grant) begin
            r_ar_valid <= 1'b1;
            r_ar_addr  <= w_sel_addr & LineMask;
            r_ar_id    <= IdWidth'(w_win);
            r_ptr      <= (w_win == PtrW'(NumReq - 1)) ? '0 : w_win + PtrW'(1);
        end else if (ar_ready_i) begin
            r_ar_valid <= 1'b0;
        end
    end

    assign ar_valid_o = r_ar_valid;
    assign ar_addr_o  = r_ar_addr;
    assign ar_id_o    = r_ar_id;
    assign ar_len_o   = 8'(Beats - 1);
    assign ar_size_o  = 3'($clog2(DataWidth / 8));
    assign ar_burst_o = 2'b01;

    // Out-of-range IDs are sunk here so a bad slave cannot wedge the R channel.
    assign w_id_ok     = |w_id_hit;
    assign rsp_valid_o = w_id_hit & {NumReq{r_valid_i}};
    assign r_ready_o   = w_id_ok ? |(w_id_hit & rsp_ready_i) : 1'b1;
    assign rsp_data_o  = r_data_i;
    assign rsp_last_o  = r_last_i;
    assign rsp_err_o   = r_resp_i[1];
    assign w_r_last_hs = r_valid_i && r_ready_o && r_last_i;

    // A last beat with a zero count belongs to a pre-reset burst and is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumReq); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NumReq); i++) begin
                if (w_req_hs[i] && !(w_r_last_hs && w_id_hit[i])) begin
                    r_cnt[i] <= r_cnt[i] + CntW'(1);
                end else if (!w_req_hs[i] && w_r_last_hs && w_id_hit[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_err <= 1'b0;
        end else if (r_valid_i && !w_id_ok) begin
            r_id_err <= 1'b1;
        end
    end

    assign id_err_o = r_id_err;

endmodule

// File: tb/tb_cachepool_refill_arbiter.sv
// Directed bench for cachepool_refill_arbiter: AR and R expectations are queued by the stimulus and popped by monitors.
module tb_cachepool_refill_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  id;
    } ar_t;

    typedef struct packed {
        logic [3:0]   vld;
        logic [255:0] data;
        logic         last;
        logic         err;
    } r_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_addr;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [255:0] rsp_data;
    logic         rsp_last;
    logic         rsp_err;
    logic         ar_valid;
    logic         ar_ready;
    logic [31:0]  ar_addr;
    logic [2:0]   ar_id;
    logic [7:0]   ar_len;
    logic [2:0]   ar_size;
    logic [1:0]   ar_burst;
    logic         r_valid;
    logic         r_ready;
    logic [255:0] r_data;
    logic [2:0]   r_id;
    logic         r_last;
    logic [1:0]   r_resp;
    logic         id_err;

    ar_t q_ar[$];
    r_t  q_r[$];
    int  n_chk;
    int  n_fail;

    cachepool_refill_arbiter #(
        .NumReq(4), .AddrWidth(32), .DataWidth(256), .LineWidth(512),
        .IdWidth(3), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .ar_id_o(ar_id), .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_burst_o(ar_burst),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_id_i(r_id),
        .r_last_i(r_last), .r_resp_i(r_resp), .id_err_o(id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_r(input logic v, input logic [2:0] id, input logic [255:0] d,
                         input logic l, input logic [1:0] rsp);
        r_valid = v;
        r_id    = id;
        r_data  = d;
        r_last  = l;
        r_resp  = rsp;
    endtask

    task automatic push_r(input logic [3:0] v, input logic [255:0] d, input logic l, input logic e);
        r_t t;
        t.vld = v; t.data = d; t.last = l; t.err = e;
        q_r.push_back(t);
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [2:0] id);
        ar_t t;
        t.addr = a; t.id = id;
        q_ar.push_back(t);
    endtask

    task automatic chk_cnts(input string nm, input int e0, input int e1, input int e2, input int e3);
        chk({nm, "_cnt0"}, 256'(dut.r_cnt[0]), 256'(e0));
        chk({nm, "_cnt1"}, 256'(dut.r_cnt[1]), 256'(e1));
        chk({nm, "_cnt2"}, 256'(dut.r_cnt[2]), 256'(e2));
        chk({nm, "_cnt3"}, 256'(dut.r_cnt[3]), 256'(e3));
    endtask

    function automatic logic [31:0] rr_addr(input int i);
        return 32'(i + 1) << 28;
    endfunction

    // AR and R monitors: every handshake must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ar_valid && ar_ready) begin
                if (q_ar.size() == 0) begin
                    chk("ar_unexpected", {ar_addr, ar_id}, 256'h0);
                end else begin
                    ar_t e;
                    e = q_ar.pop_front();
                    chk("ar_addr", ar_addr, e.addr);
                    chk("ar_id", ar_id, e.id);
                end
            end
            if (r_valid && r_ready) begin
                if (q_r.size() == 0) begin
                    chk("r_unexpected", rsp_valid, 4'h0);
                end else begin
                    r_t e;
                    e = q_r.pop_front();
                    chk("rsp_valid", rsp_valid, e.vld);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_last", rsp_last, e.last);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = '0; req_addr = '0; rsp_ready = 4'hF; ar_ready = 1'b1;
        set_r(1'b0, 3'd0, '0, 1'b0, 2'b00);

        // Reset values
        tick();
        mid();
        chk("rst_ar_valid", ar_valid, 1'b0);
        chk("rst_ar_addr", ar_addr, 32'h0);
        chk("rst_ar_id", ar_id, 3'd0);
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_id_err", id_err, 1'b0);
        chk_cnts("rst", 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Single request, two-beat line
        req_addr[31:0] = 32'h8000_0047;
        req_valid = 4'b0001;
        push_ar(32'h8000_0040, 3'd0);
        mid();
        chk("t1_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        mid();
        chk("t1_ar_valid", ar_valid, 1'b1);
        chk("t1_ar_len", ar_len, 8'd1);
        chk("t1_ar_size", ar_size, 3'd5);
        chk("t1_ar_burst", ar_burst, 2'b01);
        chk("t1_req_ready_drop", req_ready, 4'h0);
        chk_cnts("t1_issued", 1, 0, 0, 0);
        tick();
        set_r(1'b1, 3'd0, 256'hA1, 1'b0, 2'b00);
        push_r(4'b0001, 256'hA1, 1'b0, 1'b0);
        tick();
        set_r(1'b1, 3'd0, 256'hB2, 1'b1, 2'b00);
        push_r(4'b0001, 256'hB2, 1'b1, 1'b0);
        tick();
        r_valid = 1'b0;
        chk_cnts("t1_done", 0, 0, 0, 0);

        // Round-robin with all four requesters pending until the cap is hit
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = rr_addr(i) + 32'h13;
        req_valid = 4'hF;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) push_ar(rr_addr(k % 4), 3'(k % 4));
            mid();
            chk("t2_rr_grant", req_ready, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
            tick();
        end
        chk_cnts("t2_capped", 2, 2, 2, 2);
        set_r(1'b1, 3'd2, 256'hC3, 1'b1, 2'b00);
        push_r(4'b0100, 256'hC3, 1'b1, 1'b0);
        mid();
        chk("t2_still_capped", req_ready, 4'h0);
        tick();
        r_valid = 1'b0;
        push_ar(rr_addr(2), 3'd2);
        mid();
        chk("t2_regrant_2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            set_r(1'b1, 3'(k / 2), 256'(k + 16), 1'b1, 2'b00);
            push_r(4'b0001 << (k / 2), 256'(k + 16), 1'b1, 1'b0);
            tick();
        end
        r_valid = 1'b0;
        chk_cnts("t2_drained", 0, 0, 0, 0);

        // AR backpressure with requester 2 held pending
        ar_ready = 1'b0;
        req_addr[64 +: 32] = 32'h2000_00AB;
        req_valid = 4'b0100;
        push_ar(32'h2000_0080, 3'd2);
        mid();
        chk("t3_grant", req_ready, 4'b0100);
        tick();
        for (int s = 0; s < 5; s++) begin
            mid();
            chk("t3_hold_valid", ar_valid, 1'b1);
            chk("t3_hold_addr", ar_addr, 32'h2000_0080);
            chk("t3_hold_id", ar_id, 3'd2);
            chk("t3_hold_ready", req_ready, 4'h0);
            tick();
        end
        ar_ready = 1'b1;
        push_ar(32'h2000_0080, 3'd2);
        mid();
        chk("t3_release_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        set_r(1'b1, 3'd2, 256'h31, 1'b1, 2'b00);
        push_r(4'b0100, 256'h31, 1'b1, 1'b0);
        tick();
        set_r(1'b1, 3'd2, 256'h32, 1'b1, 2'b00);
        push_r(4'b0100, 256'h32, 1'b1, 1'b0);
        tick();
        r_valid = 1'b0;
        chk_cnts("t3_drained", 0, 0, 0, 0);

        // R steering under requester backpressure; stray last leaves cnt at 0
        set_r(1'b1, 3'd3, 256'hD4, 1'b1, 2'b00);
        rsp_ready = 4'b0111;
        mid();
        chk("t4_r_ready_blocked", r_ready, 1'b0);
        chk("t4_rsp_valid", rsp_valid, 4'b1000);
        tick();
        rsp_ready = 4'hF;
        push_r(4'b1000, 256'hD4, 1'b1, 1'b0);
        mid();
        chk("t4_r_ready_open", r_ready, 1'b1);
        tick();
        r_valid = 1'b0;
        chk("t4_cnt3_sat", 256'(dut.r_cnt[3]), 256'd0);

        // Simultaneous increment and decrement for requester 1, then an error beat
        req_valid = 4'b0010;
        push_ar(32'h2000_0000, 3'd1);
        mid();
        tick();
        set_r(1'b1, 3'd1, 256'hE5, 1'b1, 2'b00);
        push_r(4'b0010, 256'hE5, 1'b1, 1'b0);
        push_ar(32'h2000_0000, 3'd1);
        mid();
        chk("t5_both_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        chk("t5_cnt1_same", 256'(dut.r_cnt[1]), 256'd1);
        set_r(1'b1, 3'd1, 256'hF6, 1'b1, 2'b10);
        push_r(4'b0010, 256'hF6, 1'b1, 1'b1);
        mid();
        chk("t5_rsp_err", rsp_err, 1'b1);
        tick();
        r_valid = 1'b0;
        chk("t5_cnt1_zero", 256'(dut.r_cnt[1]), 256'd0);

        // Out-of-range ID is dropped and flagged stickily
        set_r(1'b1, 3'd4, 256'h77, 1'b1, 2'b00);
        push_r(4'b0000, 256'h77, 1'b1, 1'b0);
        mid();
        chk("t6_bad_r_ready", r_ready, 1'b1);
        chk("t6_bad_rsp_valid", rsp_valid, 4'h0);
        tick();
        r_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            mid();
            chk("t6_id_err_sticky", id_err, 1'b1);
            tick();
        end

        // Reset in the middle of a burst with a stalled AR
        ar_ready = 1'b0;
        req_valid = 4'b0001;
        mid();
        tick();
        req_valid = '0;
        set_r(1'b1, 3'd0, 256'h11, 1'b0, 2'b00);
        push_r(4'b0001, 256'h11, 1'b0, 1'b0);
        mid();
        chk("t7_pre_ar_valid", ar_valid, 1'b1);
        tick();
        r_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_ar_valid", ar_valid, 1'b0);
        chk("t7_rst_ar_addr", ar_addr, 32'h0);
        chk("t7_rst_id_err", id_err, 1'b0);
        chk_cnts("t7_rst", 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        ar_ready = 1'b1;
        set_r(1'b1, 3'd0, 256'h22, 1'b1, 2'b00);
        push_r(4'b0001, 256'h22, 1'b1, 1'b0);
        tick();
        r_valid = 1'b0;
        chk("t7_cnt0_sat", 256'(dut.r_cnt[0]), 256'd0);

        repeat (3) tick();
        chk("end_ar_queue_empty", 256'(q_ar.size()), 256'd0);
        chk("end_r_queue_empty", 256'(q_r.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cachepool_refill_arbiter.md
Name: cachepool_refill_arbiter

Overview:
- Shares one wide AXI read port (AR/R) among NumReq L1 cache-bank refill requesters in a CachePool tile.
- Arbitrates line-refill requests round-robin and issues one INCR burst per cache line, tagged with the requester index as AXI ID.
- Steers R beats back to the owner by ID.
- Tracks outstanding refills per requester and caps them at MaxOutstanding.

Parameters:
- NumReq, 4, number of refill requesters (cache banks).
- AddrWidth, 32, AXI address width.
- DataWidth, 256, AXI data width (one beat).
- LineWidth, 512, cache-line width; Beats = LineWidth/DataWidth, which must be an integer ≥ 1.
- IdWidth, 2, AXI ID width; must be ≥ $clog2(NumReq).
- MaxOutstanding, 2, maximum in-flight refills per requester (≥ 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  refill request valid, one bit per requester.
- req_ready_o  out  NumReq  refill request accepted.
- req_addr_i  in  NumReq*AddrWidth  refill byte address; requester i occupies slice i.
- rsp_valid_o  out  NumReq  refill data beat valid for requester i.
- rsp_ready_i  in  NumReq  requester i accepts the beat.
- rsp_data_o  out  DataWidth  beat data, shared by all requesters.
- rsp_last_o  out  1  last beat of the line.
- rsp_err_o  out  1  beat carries SLVERR/DECERR (r_resp_i[1]).
- ar_valid_o  out  1  AXI AR valid.
- ar_ready_i  in  1  AXI AR ready.
- ar_addr_o  out  AddrWidth  line-aligned burst address.
- ar_id_o  out  IdWidth  requester index, zero-extended.
- ar_len_o  out  8  Beats-1.
- ar_size_o  out  3  $clog2(DataWidth/8).
- ar_burst_o  out  2  2'b01 (INCR).
- r_valid_i  in  1  AXI R valid.
- r_ready_o  out  1  AXI R ready.
- r_data_i  in  DataWidth  AXI R data.
- r_id_i  in  IdWidth  AXI R ID.
- r_last_i  in  1  AXI R last.
- r_resp_i  in  2  AXI R response.
- id_err_o  out  1  sticky flag: an R beat arrived with r_id_i ≥ NumReq.

Behaviour:
- Reset values:
  - ar_valid_o=0, ar_addr_o=0, ar_id_o=0.
  - RR pointer=0, all outstanding counters=0, id_err_o=0.
  - req_ready_o=0.
  - rsp_valid_o, r_ready_o and the rsp_* outputs follow the combinational R path.
- Eligibility: requester i is eligible when req_valid_i[i]=1 and cnt[i] < MaxOutstanding.
- AR stage:
  - One-entry register. It is "free" when ar_valid_o=0, or when ar_valid_o && ar_ready_i this cycle.
  - When free and at least one requester is eligible, the winner is the first eligible index at or after the RR pointer, wrapping modulo NumReq.
  - req_ready_o[winner]=1 for that cycle only; all other req_ready_o bits are 0.
  - Next cycle: ar_valid_o=1, ar_addr_o = req_addr_i[winner] with the low $clog2(LineWidth/8) bits cleared, ar_id_o=winner.
  - RR pointer becomes (winner+1) mod NumReq.
  - Latency from request to AR valid is 1 cycle. Throughput is 1 AR per cycle under continuous ar_ready_i.
  - While ar_valid_o && !ar_ready_i, all AR outputs are held stable (AXI rule) and req_ready_o=0.
- Outstanding counters:
  - cnt[i] increments on a req handshake for i.
  - cnt[i] decrements on an R handshake with r_last_i=1 and r_id_i=i.
  - If both happen in the same cycle, cnt[i] is unchanged.
  - cnt[i] never exceeds MaxOutstanding and never underflows. A last beat arriving with cnt=0 leaves cnt at 0.
- R path (combinational, zero latency):
  - If r_id_i < NumReq: rsp_valid_o[r_id_i]=r_valid_i, r_ready_o=rsp_ready_i[r_id_i]; every other rsp_valid_o bit is 0.
  - rsp_data_o=r_data_i, rsp_last_o=r_last_i, rsp_err_o=r_resp_i[1].
  - If r_id_i ≥ NumReq: r_ready_o=1 (beat dropped), all rsp_valid_o=0, and id_err_o is set on r_valid_i. id_err_o clears only on reset.
- AR and R are independent: the same requester may have its AR issued and an R beat delivered in the same cycle.
- Reset mid-burst: all state clears immediately (asynchronously). Responses to bursts issued before reset are routed by ID as usual; their counter decrements saturate at 0.

Test Plan:
- Single request: req_valid_i=4'b0001, addr 0x8000_0047 → req_ready_o[0] pulses, next cycle AR addr 0x8000_0040, id 0, len 1, size 5, burst 1. Two R beats with last on the 2nd → rsp_valid_o[0] on both beats, rsp_last_o on beat 2, cnt[0] returns to 0.
- Round-robin: all four requesters valid continuously, ar_ready_i=1 → AR IDs 0,1,2,3,0… on consecutive cycles; each requester stops after 2 grants (MaxOutstanding) until it receives an R last.
- AR backpressure: ar_ready_i=0 for 5 cycles with requester 2 pending → ar_addr_o/ar_id_o stable for all 5 cycles and req_ready_o=0 throughout; the handshake completes in the cycle ar_ready_i=1.
- R steering/backpressure: r_id_i=3, rsp_ready_i=4'b0111 → r_ready_o=0 and rsp_valid_o=4'b1000; setting rsp_ready_i[3]=1 completes the beat.
- Simultaneous counter events: cnt[1]=1, req handshake for 1 and R last for id 1 in the same cycle → cnt[1] stays 1. Error beat with r_resp_i=2'b10 → rsp_err_o=1.
- Bad ID: r_id_i=4 with IdWidth=3 → r_ready_o=1, rsp_valid_o=0, id_err_o=1 until rst_ni falls. Reset asserted mid-burst → ar_valid_o=0 and all counters 0 in the same cycle.
